spi_slave: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 17 +
 rtl/spi_slave_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 163 ++++++++++++++++
 tb/tb_spi_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, bit counter width, underrun fill byte.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_slave_pkg;

    // Byte shifted to the host when nothing was queued for transmission
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    // Bits per frame is 8, so a 3-bit counter wraps exactly at the byte boundary
    localparam int BIT_CNT_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// N-stage synchronizer for one async input, plus a history flop giving rise/fall strobes.
// Latency: STAGES clk to q, strobes valid in the cycle q changes; strobe registered use adds 1 clk.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module spi_slave_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Shift the async input through the synchronizer and remember the previous synced value
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            hist  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled SCK/SS_n/MOSI, 8-bit MSB-first frames, one-deep TX buffer.
// Latency: pin edge to action SYNC_STAGES+1 clk; received byte on do_dat then dsr pulse 1 clk later.
// Backpressure: wr honoured only while tx_ready=1; an empty buffer at a byte start sends IDLE_BYTE.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] di,
    input  logic       wr,
    output logic       tx_ready,
    output logic [7:0] do_dat,
    output logic       dsr,
    output logic       underrun,
    output logic       busy
);

    logic ss_unused_q, ss_rise, ss_fall;
    logic sck_unused_q, sck_rise, sck_fall;
    logic mosi_q, mosi_unused_rise, mosi_unused_fall;

    // ss_n idles high, so its synchronizer resets high to avoid a false select at reset release
    spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(ss_n), .q(ss_unused_q), .rise(ss_rise), .fall(ss_fall)
    );

    spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .d(sck), .q(sck_unused_q), .rise(sck_rise), .fall(sck_fall)
    );

    // Same depth as sck so the sampled data bit lines up with the sck rise strobe
    spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_q), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    spi_state_t           state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rxsh;
    logic [7:0]           txsh;
    logic [7:0]           tx_buf;
    logic                 load_pend;  // a byte completed; next byte loads at the following sck fall
    logic                 load_q;     // shifter was loaded last clk; present its MSB on miso
    logic                 done_q;     // do_dat updated last clk; fire dsr now

    logic enter, desel, sel_active, load, shift, rx_evt;

    assign enter      = (state == ST_IDLE) && ss_fall;
    assign desel      = (state == ST_SEL) && ss_rise;
    // Deselect has priority over any sck edge seen in the same clk
    assign sel_active = (state == ST_SEL) && !ss_rise;
    assign load       = enter || (sel_active && sck_fall && load_pend);
    assign shift      = sel_active && sck_fall && !load_pend;
    assign rx_evt     = sel_active && sck_rise;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: select on synced ss_n fall, release on synced ss_n rise regardless of bit count
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ss_fall) state_nxt = ST_SEL;
            ST_SEL:  if (ss_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        miso_oe = (state == ST_SEL);
        busy    = (state == ST_SEL) && (bit_cnt != '0);
    end

    // Datapath: TX buffer handshake, shifters, bit counter, receive strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            miso      <= 1'b0;
            do_dat    <= 8'h00;
            dsr       <= 1'b0;
            tx_ready  <= 1'b1;
            underrun  <= 1'b0;
            bit_cnt   <= '0;
            rxsh      <= 8'h00;
            txsh      <= 8'h00;
            tx_buf    <= 8'h00;
            load_pend <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_q <= load;
            done_q <= 1'b0;
            dsr    <= done_q;

            if (load) begin
                load_pend <= 1'b0;
                if (!tx_ready) begin
                    // Queued byte goes out; a same-clk wr refills the buffer behind it
                    txsh     <= tx_buf;
                    tx_ready <= !wr;
                    if (wr) begin
                        tx_buf   <= di;
                        underrun <= 1'b0;
                    end
                end else begin
                    txsh     <= IDLE_BYTE;
                    underrun <= 1'b1;
                    if (wr) begin
                        tx_buf   <= di;
                        tx_ready <= 1'b0;
                        underrun <= 1'b0;
                    end
                end
            end else if (wr && tx_ready) begin
                tx_buf   <= di;
                tx_ready <= 1'b0;
                underrun <= 1'b0;
            end

            if (load_q && state == ST_SEL) begin
                miso <= txsh[7];
            end

            if (shift) begin
                txsh <= {txsh[6:0], 1'b0};
                miso <= txsh[6];
            end

            if (rx_evt) begin
                rxsh    <= {rxsh[6:0], mosi_q};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == '1) begin
                    do_dat    <= {rxsh[6:0], mosi_q};
                    done_q    <= 1'b1;
                    load_pend <= 1'b1;
                end
            end

            // Partial byte is dropped; buffer contents are left for the next select
            if (desel) begin
                bit_cnt   <= '0;
                rxsh      <= 8'h00;
                miso      <= 1'b0;
                load_pend <= 1'b0;
                done_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ss_n = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] di = 8'h00;
    logic       wr = 1'b0;
    logic       tx_ready;
    logic [7:0] do_dat;
    logic       dsr;
    logic       underrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int dsr_cnt = 0;

    spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .di(di), .wr(wr), .tx_ready(tx_ready),
        .do_dat(do_dat), .dsr(dsr), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dsr) dsr_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        di = d;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic ss_assert();
        ss_n = 1'b0;
        wait_clk(16);
    endtask

    task automatic ss_release();
        wait_clk(8);
        ss_n = 1'b1;
        wait_clk(16);
    endtask

    // Host side of one frame: mosi set before rise, miso sampled as sck rises
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(8);
            sck = 1'b1;
            rx = {rx[6:0], miso};
            wait_clk(8);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(4);
        n_cmp++; if (miso !== 1'b0)     begin n_bad++; $display("FAIL rst_miso got %b want 0", miso); end
        n_cmp++; if (miso_oe !== 1'b0)  begin n_bad++; $display("FAIL rst_miso_oe got %b want 0", miso_oe); end
        n_cmp++; if (do_dat !== 8'h00)  begin n_bad++; $display("FAIL rst_do got %h want 00", do_dat); end
        n_cmp++; if (dsr !== 1'b0)      begin n_bad++; $display("FAIL rst_dsr got %b want 0", dsr); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got %b want 0", underrun); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        reset = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_basic();
        logic [7:0] rx;
        dsr_cnt = 0;
        write_byte(8'hA5);
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_tx_ready_after_wr got %b want 0", tx_ready); end
        ss_assert();
        n_cmp++; if (miso_oe !== 1'b1) begin n_bad++; $display("FAIL basic_miso_oe got %b want 1", miso_oe); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL basic_tx_ready_after_load got %b want 1", tx_ready); end
        spi_byte(8'h3C, 8, rx);
        ss_release();
        n_cmp++; if (rx !== 8'hA5)     begin n_bad++; $display("FAIL basic_host_rx got %h want A5", rx); end
        n_cmp++; if (do_dat !== 8'h3C) begin n_bad++; $display("FAIL basic_do got %h want 3C", do_dat); end
        n_cmp++; if (dsr_cnt !== 1)    begin n_bad++; $display("FAIL basic_dsr_count got %0d want 1", dsr_cnt); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL basic_miso_oe_after got %b want 0", miso_oe); end
    endtask

    task automatic test_underrun();
        logic [7:0] rx;
        dsr_cnt = 0;
        ss_assert();
        spi_byte(8'h81, 8, rx);
        ss_release();
        n_cmp++; if (rx !== 8'hFF)      begin n_bad++; $display("FAIL udr_host_rx got %h want FF", rx); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL udr_flag got %b want 1", underrun); end
        n_cmp++; if (do_dat !== 8'h81)  begin n_bad++; $display("FAIL udr_do got %h want 81", do_dat); end
        write_byte(8'h77);
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL udr_clear got %b want 0", underrun); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL udr_tx_ready got %b want 0", tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx1, rx2;
        int t;
        // Drain the byte left over from the previous test so the buffer is empty
        ss_assert();
        ss_release();
        dsr_cnt = 0;
        write_byte(8'h10);
        fork
            begin
                ss_assert();
                spi_byte(8'h01, 8, rx1);
                spi_byte(8'h02, 8, rx2);
                ss_release();
            end
            begin
                t = 0;
                while (!dsr && t < 400) begin
                    @(negedge clk);
                    t++;
                end
                n_cmp++; if (t >= 400) begin n_bad++; $display("FAIL b2b_dsr_timeout got %0d clk want <400", t); end
                write_byte(8'h20);
            end
        join
        n_cmp++; if (rx1 !== 8'h10)    begin n_bad++; $display("FAIL b2b_rx1 got %h want 10", rx1); end
        n_cmp++; if (rx2 !== 8'h20)    begin n_bad++; $display("FAIL b2b_rx2 got %h want 20", rx2); end
        n_cmp++; if (do_dat !== 8'h02) begin n_bad++; $display("FAIL b2b_do got %h want 02", do_dat); end
        n_cmp++; if (dsr_cnt !== 2)    begin n_bad++; $display("FAIL b2b_dsr_count got %0d want 2", dsr_cnt); end
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        dsr_cnt = 0;
        write_byte(8'h77);
        ss_assert();
        spi_byte(8'hAA, 5, rx);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL part_busy got %b want 1", busy); end
        ss_release();
        n_cmp++; if (dsr_cnt !== 0)    begin n_bad++; $display("FAIL part_no_dsr got %0d want 0", dsr_cnt); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL part_busy_after got %b want 0", busy); end
        n_cmp++; if (miso !== 1'b0)    begin n_bad++; $display("FAIL part_miso_after got %b want 0", miso); end
        n_cmp++; if (do_dat !== 8'h02) begin n_bad++; $display("FAIL part_do_held got %h want 02", do_dat); end
        ss_assert();
        spi_byte(8'hC3, 8, rx);
        ss_release();
        n_cmp++; if (do_dat !== 8'hC3) begin n_bad++; $display("FAIL part_do got %h want C3", do_dat); end
        n_cmp++; if (dsr_cnt !== 1)    begin n_bad++; $display("FAIL part_dsr_count got %0d want 1", dsr_cnt); end
        n_cmp++; if (rx !== 8'hFF)     begin n_bad++; $display("FAIL part_host_rx got %h want FF", rx); end
    endtask

    task automatic test_wr_ignored();
        logic [7:0] rx;
        write_byte(8'h55);
        write_byte(8'hEE);
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL ign_tx_ready got %b want 0", tx_ready); end
        ss_assert();
        spi_byte(8'h5A, 8, rx);
        ss_release();
        n_cmp++; if (rx !== 8'h55)     begin n_bad++; $display("FAIL ign_host_rx got %h want 55", rx); end
        n_cmp++; if (do_dat !== 8'h5A) begin n_bad++; $display("FAIL ign_do got %h want 5A", do_dat); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rx;
        dsr_cnt = 0;
        write_byte(8'h9A);
        ss_assert();
        spi_byte(8'hF0, 4, rx);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (miso_oe !== 1'b0)  begin n_bad++; $display("FAIL mrst_miso_oe got %b want 0", miso_oe); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_tx_ready got %b want 1", tx_ready); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL mrst_busy got %b want 0", busy); end
        n_cmp++; if (do_dat !== 8'h00)  begin n_bad++; $display("FAIL mrst_do got %h want 00", do_dat); end
        spi_byte(8'h0F, 4, rx);
        ss_release();
        n_cmp++; if (dsr_cnt !== 0)     begin n_bad++; $display("FAIL mrst_no_dsr got %0d want 0", dsr_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_partial();
        test_wr_ignored();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
